if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage sitting directly upstream of the instruction memory (IM) and directly upstream of decode. Owns the program counter, drives the IM byte address, pairs each registered IM word with the PC that produced it, and hands instructions to decode over a valid/ready handshake. Handles decode back-pressure by re-issuing the held address and handles taken branches/jumps from execute by redirecting the PC and squashing the wrong-path word.

## Interface
- ADDR_W, 8: IM byte-address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 32: instruction width.
- RESET_PC, 8'h00: PC value loaded on reset.
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fetch_en  in  1  1 = issue new fetches; 0 = stop issuing, drain.
- redirect_valid  in  1  execute requests PC change this cycle.
- redirect_target  in  ADDR_W  new PC; bits [1:0] ignored (forced 0).
- im_adr  out  ADDR_W  address to IM (IM registers its read on the same edge).
- im_dout  in  DATA_W  IM registered read data (word for address issued last cycle).
- instr_valid  out  1  instr/instr_pc hold a valid, in-path instruction.
- instr  out  DATA_W  instruction word (= im_dout).
- instr_pc  out  ADDR_W  byte address of instr.
- dec_ready  in  1  decode accepts instr this cycle.
- fetch_count  out  16  instructions accepted by decode since reset, wraps.

## Operation
- State: pc_q (next address to issue), req_pc_q (address issued last cycle), req_valid_q (last issue was a real fetch), fetch_count.
- instr_valid = req_valid_q & ~redirect_valid; instr = im_dout; instr_pc = req_pc_q.
- fire = instr_valid & dec_ready; stall = instr_valid & ~dec_ready.
- Address select, priority order:
  - redirect_valid: im_adr = {redirect_target[ADDR_W-1:2],2'b00}; pc_q <= that + 4; req_valid_q <= 1 (regardless of fetch_en).
  - stall: im_adr = req_pc_q (re-read same word); pc_q, req_pc_q hold; req_valid_q stays 1.
  - fetch_en: im_adr = pc_q; pc_q <= pc_q + 4; req_valid_q <= 1.
  - else: im_adr = pc_q; pc_q holds; req_valid_q <= 0.
- req_pc_q <= im_adr every edge.
- fetch_count <= fetch_count + 1 on fire; 16-bit wrap.
- PC arithmetic unsigned, modulo 2^ADDR_W: 8'hFC + 4 = 8'h00.
- Contents of unprogrammed IM addresses are not interpreted; the stage delivers whatever im_dout holds.
- Combinational path dec_ready/redirect_valid -> im_adr is intentional (IM has no enable).

## Timing
- Reset (async assert): pc_q = RESET_PC, req_pc_q = RESET_PC, req_valid_q = 0, fetch_count = 0; thus instr_valid = 0, im_adr = RESET_PC, instr_pc = RESET_PC.
- First instruction: reset deasserted with fetch_en = 1; edge 1 issues RESET_PC; instr_valid = 1 after edge 1. One-cycle latency issue -> instr_valid.
- Steady state with dec_ready = 1: one instruction per cycle, PCs +4 each cycle.
- Stall: instr/instr_pc held stable for every cycle dec_ready = 0; no word skipped or duplicated after release.
- Redirect: wrong-path word at output squashed in the redirect cycle; target word valid the next cycle; target+4 the one after. Redirect during stall: redirect wins, stalled word dropped.
- fetch_en low: instr in flight still delivered (and held under stall); afterwards instr_valid = 0, pc_q frozen; re-raising resumes at pc_q with one-cycle bubble.
- Reset mid-stream: outputs return to reset values asynchronously; in-flight word discarded.

## Structure
- Shared package: ADDR_W, DATA_W, RESET_PC, PC_STEP = 4, fetch_count width.
- One natural sub-module: pc_gen (pc_q register, +4 incrementer, redirect/stall/enable priority mux producing im_adr and next PC). Handshake, squash and counter stay in if_fetch.

## Test plan
- Reset then fetch_en = 1, dec_ready = 1 with IM loaded with the team sort program: instr_pc 00,04,08 deliver 00450693, 00100713, 00b76463 on consecutive cycles; fetch_count = 3.
- Stall: drop dec_ready 3 cycles while instr_pc = 08 -> 00b76463 held 4 cycles, next accepted is 0c/00008067; fetch_count increments once for 08.
- Redirect to 8'h1c while instr_pc = 48 valid -> instr_valid = 0 that cycle, next cycle instr_pc = 1c, instr = ffc62883, then 20/01185a63.
- Redirect with target 8'h1e and dec_ready = 0 -> im_adr = 1c, stalled word dropped, next output 1c.
- Wrap: redirect to FC -> instr_pc FC then 00 (00450693).
- fetch_en low mid-stream plus async reset mid-stall -> instr_valid 0, im_adr = 00, fetch_count = 0 immediately.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
// Shared constants for the instruction-fetch stage: address/data widths,
// reset PC, PC increment and fetch-counter width, plus the word-alignment
// helper used on redirect targets.
// -----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
    localparam logic [ADDR_W-1:0] PC_STEP  = 8'd4;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 16'd1;

    // Instructions are word aligned; the two low byte-offset bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// if_fetch_pc_gen
// Owns the program counter and selects the address issued to instruction
// memory this cycle.  Priority: redirect > stall (re-read held word) >
// fetch enable (advance) > idle (hold, no real fetch).
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_fetch_en            issue new sequential fetches
//   i_redirect_valid      execute redirects the PC this cycle
//   i_redirect_target     new PC (low two bits ignored)
//   i_stall               decode is back-pressuring a valid word
//   i_req_pc              address issued last cycle (re-issued on stall)
//   o_im_adr              address driven to instruction memory
//   o_issue               this cycle's issue is a real fetch
// -----------------------------------------------------------------------------
module if_fetch_pc_gen
    import if_fetch_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_en,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_target,
    input  logic              i_stall,
    input  logic [ADDR_W-1:0] i_req_pc,
    output logic [ADDR_W-1:0] o_im_adr,
    output logic              o_issue
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_redir_adr;

    always_comb begin
        w_redir_adr = word_align(i_redirect_target);
        o_im_adr    = r_pc;
        w_pc_nxt    = r_pc;
        o_issue     = 1'b0;
        if (i_redirect_valid) begin
            o_im_adr = w_redir_adr;
            w_pc_nxt = w_redir_adr + PC_STEP;
            o_issue  = 1'b1;
        end else if (i_stall) begin
            // IM has no enable, so the held word is kept alive by re-reading it.
            o_im_adr = i_req_pc;
            o_issue  = 1'b1;
        end else if (i_fetch_en) begin
            w_pc_nxt = r_pc + PC_STEP;
            o_issue  = 1'b1;
        end
    end

    // Issue stage -> PC register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage between instruction memory and decode.  Pairs each
// registered IM word with the PC that produced it, presents it to decode over
// a valid/ready handshake, squashes the wrong-path word on a redirect and
// counts instructions accepted by decode.
//
// Ports:
//   i_clock, i_reset      clock, asynchronous active-high reset
//   i_fetch_en            1 = issue new fetches, 0 = drain
//   i_redirect_valid      execute requests a PC change this cycle
//   i_redirect_target     new PC (bits [1:0] ignored)
//   o_im_adr              byte address to IM (registered inside IM)
//   i_im_dout             IM read data for the address issued last cycle
//   o_instr_valid         o_instr/o_instr_pc hold a valid in-path instruction
//   o_instr, o_instr_pc   instruction word and its byte address
//   i_dec_ready           decode accepts the instruction this cycle
//   o_fetch_count         instructions accepted since reset (wraps)
// -----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_fetch_en,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_target,
    output logic [ADDR_W-1:0] o_im_adr,
    input  logic [DATA_W-1:0] i_im_dout,
    output logic              o_instr_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_instr_pc,
    input  logic              i_dec_ready,
    output logic [CNT_W-1:0]  o_fetch_count
);

    logic [ADDR_W-1:0] r_req_pc_p1;
    logic              r_req_vld_p1;
    logic [CNT_W-1:0]  r_fetch_count;

    logic              w_instr_valid;
    logic              w_fire;
    logic              w_stall;
    logic [ADDR_W-1:0] w_im_adr;
    logic              w_issue;

    // A redirect means the word now at the output is on the wrong path.
    assign w_instr_valid = r_req_vld_p1 & ~i_redirect_valid;
    assign w_fire        = w_instr_valid & i_dec_ready;
    assign w_stall       = w_instr_valid & ~i_dec_ready;

    if_fetch_pc_gen u_pc_gen (
        .i_clk             (i_clock),
        .i_rst             (i_reset),
        .i_fetch_en        (i_fetch_en),
        .i_redirect_valid  (i_redirect_valid),
        .i_redirect_target (i_redirect_target),
        .i_stall           (w_stall),
        .i_req_pc          (r_req_pc_p1),
        .o_im_adr          (w_im_adr),
        .o_issue           (w_issue)
    );

    // Issue stage -> IM response stage (aligned with i_im_dout)
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_req_pc_p1   <= RESET_PC;
            r_req_vld_p1  <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_req_pc_p1  <= w_im_adr;
            r_req_vld_p1 <= w_issue;
            if (w_fire) begin
                r_fetch_count <= r_fetch_count + CNT_ONE;
            end
        end
    end

    assign o_im_adr      = w_im_adr;
    assign o_instr_valid = w_instr_valid;
    assign o_instr       = i_im_dout;
    assign o_instr_pc    = r_req_pc_p1;
    assign o_fetch_count = r_fetch_count;

endmodule
